ps2_cmd_sequencer: RTL and testbench
====================================

Name: ps2_cmd_sequencer

Overview:
Bus-master controller that owns the 8-bit register port of the PS/2 keyboard interface core (reg 0 = tx/rx data, reg 1 = status).
- Continuously polls status and drains received scan bytes into a local FIFO.
- Sequences host-to-device commands with optional argument byte, 0xFA ACK matching, 0xFE resend handling, timeout abort and bounded retry.
- Sits between the keyboard core and the CPU-side input driver, so software never busy-polls the core.

Parameters:
pClkFreq, 40000000, system clock in Hz
pAckTimeoutMs, 25, ms to wait for 0xFA after a byte is written before aborting
pRetries, 3, retries per byte on 0xFE/timeout before error (2-bit counter sufficient)
pFifoDepth, 16, rx FIFO entries, power of two
pPollGap, 8, idle cycles between status polls

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
kbd_cs_o  out  1  register access strobe to keyboard core, held until kbd_ack_i
kbd_we_o  out  1  1 = write
kbd_adr_o  out  2  0 = data reg, 1 = status reg
kbd_dat_o  out  8  write data
kbd_dat_i  in  8  read data (valid with kbd_ack_i)
kbd_ack_i  in  1  single-cycle access acknowledge
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  sequencer idle, accepts command
cmd_byte_i  in  8  command byte
cmd_has_arg_i  in  1  send cmd_arg_i after cmd_byte_i is ACKed
cmd_arg_i  in  8  argument byte
cmd_done_o  out  1  pulse: all bytes ACKed
cmd_err_o  out  1  pulse: retries exhausted
rx_valid_o  out  1  FIFO non-empty
rx_data_o  out  8  FIFO head
rx_ready_i  in  1  pop when rx_valid_o & rx_ready_i
rx_ovf_o  out  1  sticky: byte dropped on full FIFO
perr_o  out  1  pulse: received byte with parity error dropped

Behaviour:
- Reset: every output 0; FIFO empty; state IDLE; rx_ovf_o cleared. Only reset clears rx_ovf_o. Reset mid-access drops kbd_cs_o the next cycle; a late kbd_ack_i is ignored.
- Bus rule: one access outstanding at a time. kbd_cs_o/we/adr/dat are stable from assertion to the cycle after kbd_ack_i, then cs is deasserted for at least 1 cycle.
- Status decode: bit7 = rx pending, bit6 = tx complete, bit0 = parity error.
- States:
  - IDLE: cmd_ready_o = 1 when no command is active. A command is accepted on cmd_valid_i & cmd_ready_o; cmd and arg are latched and cur byte = cmd. After pPollGap cycles -> POLL.
  - POLL: read status.
    - bit7 = 1 -> RD_DATA.
    - Else, if a byte is pending to send and bit6 = 1 -> WR_DATA.
    - Else, if AWAIT_ACK is active -> AWAIT.
    - Else -> IDLE.
  - RD_DATA: read reg 0, then CLR_RX, which writes 0x00 to status. Routing of the read byte:
    - Parity error: drop, pulse perr_o.
    - AWAIT_ACK active and byte = 0xFA: ACK.
    - AWAIT_ACK active and byte = 0xFE: RESEND.
    - Otherwise push to FIFO. If the FIFO is full, drop and set rx_ovf_o.
    - Then -> POLL.
  - WR_DATA: write cur byte to reg 0. Load the timeout counter with pClkFreq/1000*pAckTimeoutMs, set AWAIT_ACK, -> AWAIT.
  - AWAIT: the counter decrements every cycle while AWAIT_ACK is set, including during polls. Re-enter POLL each pPollGap. At counter = 0 -> ABORT.
  - ABORT: write 0xFF to status to clear the transmitter, then handle as RESEND.
- ACK handling: clear AWAIT_ACK and reset the retry count.
  - If cur = cmd and has_arg: cur = arg, pending.
  - Else pulse cmd_done_o and release the command.
- RESEND handling: clear AWAIT_ACK.
  - If retry count < pRetries: increment it and re-send the same cur byte.
  - Else pulse cmd_err_o and release the command.
- cmd_done_o and cmd_err_o are mutually exclusive single-cycle pulses. cmd_ready_o returns to 1 the cycle after the pulse.
- Device bytes arriving during a command that are not 0xFA/0xFE (e.g., 0xAA, scan codes) go to the FIFO.
- FIFO: simultaneous push and pop when full succeeds (no drop). Pop when empty is ignored. rx_data_o is valid combinationally from the head.
- A timeout and an ACK resolved in the same cycle: ACK wins.

Test Plan:
- Rx drain: core presents status 0x80 then data 0x1C -> the sequencer reads reg0, writes 0x00 to status, and rx_valid_o goes high with rx_data_o = 0x1C.
- LED command: cmd 0xED, arg 0x02 -> write 0xED, device replies 0xFA, write 0x02, replies 0xFA -> exactly one cmd_done_o pulse, no FIFO push.
- Resend: cmd 0xF4, device replies 0xFE, 0xFE, then 0xFA -> 0xF4 written 3 times, then cmd_done_o.
- Timeout: cmd 0xFF with no reply, pRetries = 3 -> 4 writes of 0xFF to reg0, each followed after the timeout by a 0xFF write to status, then cmd_err_o.
- Overflow: 17 bytes received with rx_ready_i = 0 and depth 16 -> 16 stored, rx_ovf_o = 1. Then pop while full with a simultaneous arrival -> no drop.
- Parity and reset: status 0x81 -> byte dropped and perr_o pulses. rst_i asserted mid-WR_DATA -> kbd_cs_o = 0 next cycle and all outputs return to 0.

Source files
------------

// File: rtl/ps2_cmd_sequencer.sv
// ps2_cmd_sequencer: owns the PS/2 keyboard core register port. It polls
// status, drains received bytes into a local FIFO and runs host-to-device
// commands (optional argument byte) with ACK/resend/timeout handling.
module ps2_cmd_sequencer #(
    parameter int pClkFreq      = 40000000,
    parameter int pAckTimeoutMs = 25,
    parameter int pRetries      = 3,
    parameter int pFifoDepth    = 16,
    parameter int pPollGap      = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       kbd_cs_o,
    output logic       kbd_we_o,
    output logic [1:0] kbd_adr_o,
    output logic [7:0] kbd_dat_o,
    input  logic [7:0] kbd_dat_i,
    input  logic       kbd_ack_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] cmd_byte_i,
    input  logic       cmd_has_arg_i,
    input  logic [7:0] cmd_arg_i,
    output logic       cmd_done_o,
    output logic       cmd_err_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    input  logic       rx_ready_i,
    output logic       rx_ovf_o,
    output logic       perr_o
);

    localparam int TMO_RAW  = (pClkFreq / 1000) * pAckTimeoutMs;
    localparam int TMO_LOAD = (TMO_RAW < 1) ? 1 : TMO_RAW;
    localparam int TW       = $clog2(TMO_LOAD + 1);
    localparam int RW       = (pRetries < 2) ? 1 : $clog2(pRetries + 1);
    localparam int AW       = (pFifoDepth < 2) ? 1 : $clog2(pFifoDepth);
    localparam int CW       = AW + 1;
    localparam int GW       = (pPollGap < 2) ? 1 : $clog2(pPollGap);

    localparam logic [1:0] ADR_DATA = 2'd0;
    localparam logic [1:0] ADR_STAT = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_RD_DATA,
        S_CLR_RX,
        S_WR_DATA,
        S_AWAIT,
        S_ABORT
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           cs_q, cs_d;
    logic           we_q, we_d;
    logic [1:0]     adr_q, adr_d;
    logic [7:0]     dout_q, dout_d;
    logic           par_q, par_d;

    logic           active_q, active_d;
    logic [7:0]     arg_q, arg_d;
    logic           has_arg_q, has_arg_d;
    logic [7:0]     cur_q, cur_d;
    logic           cur_is_arg_q, cur_is_arg_d;
    logic           pending_q, pending_d;
    logic           await_q, await_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           ready_q, ready_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           perr_q, perr_d;
    logic           ovf_q, ovf_d;

    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     mem_q [pFifoDepth];

    // Events handed from the bus FSM to the command and FIFO logic.
    logic           ack_evt, resend_evt, wr_done, accept;
    logic           fifo_push, fifo_we, fifo_pop, fifo_full;
    logic [7:0]     fifo_wdata;

    // Bus FSM: one register access at a time, request held until acknowledged.
    always_comb begin
        state_d    = state_q;
        gap_d      = '0;
        cs_d       = cs_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dout_d     = dout_q;
        par_d      = par_q;
        perr_d     = 1'b0;
        ack_evt    = 1'b0;
        resend_evt = 1'b0;
        wr_done    = 1'b0;
        fifo_push  = 1'b0;
        fifo_wdata = 8'h00;

        // cs drops the cycle after the acknowledge; every bus state re-issues
        // only from cs low, which guarantees a one-cycle gap between accesses.
        if (cs_q && kbd_ack_i) begin
            cs_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (gap_q == GW'(pPollGap - 1)) begin
                    state_d = S_POLL;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_POLL: begin
                if (!cs_q) begin
                    cs_d = 1'b1; we_d = 1'b0; adr_d = ADR_STAT; dout_d = 8'h00;
                end else if (kbd_ack_i) begin
                    par_d = kbd_dat_i[0];
                    if (kbd_dat_i[7]) begin
                        state_d = S_RD_DATA;
                    end else if (pending_q && kbd_dat_i[6]) begin
                        state_d = S_WR_DATA;
                    end else if (await_q) begin
                        state_d = S_AWAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RD_DATA: begin
                if (!cs_q) begin
                    cs_d = 1'b1; we_d = 1'b0; adr_d = ADR_DATA; dout_d = 8'h00;
                end else if (kbd_ack_i) begin
                    state_d = S_CLR_RX;
                    if (par_q) begin
                        perr_d = 1'b1;
                    end else if (await_q && kbd_dat_i == 8'hFA) begin
                        ack_evt = 1'b1;
                    end else if (await_q && kbd_dat_i == 8'hFE) begin
                        resend_evt = 1'b1;
                    end else begin
                        fifo_push  = 1'b1;
                        fifo_wdata = kbd_dat_i;
                    end
                end
            end
            S_CLR_RX: begin
                if (!cs_q) begin
                    cs_d = 1'b1; we_d = 1'b1; adr_d = ADR_STAT; dout_d = 8'h00;
                end else if (kbd_ack_i) begin
                    state_d = S_POLL;
                end
            end
            S_WR_DATA: begin
                if (!cs_q) begin
                    cs_d = 1'b1; we_d = 1'b1; adr_d = ADR_DATA; dout_d = cur_q;
                end else if (kbd_ack_i) begin
                    wr_done = 1'b1;
                    state_d = S_AWAIT;
                end
            end
            S_AWAIT: begin
                // ACK bytes are only recognised through POLL/RD_DATA, so a
                // reply already seen by the poll always beats the timeout.
                if (await_q && tmo_q == '0) begin
                    state_d = S_ABORT;
                end else if (gap_q == GW'(pPollGap - 1)) begin
                    state_d = S_POLL;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_ABORT: begin
                // 0xFF to status resets the core transmitter before a resend.
                if (!cs_q) begin
                    cs_d = 1'b1; we_d = 1'b1; adr_d = ADR_STAT; dout_d = 8'hFF;
                end else if (kbd_ack_i) begin
                    resend_evt = 1'b1;
                    state_d    = S_POLL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command bookkeeping: current byte, retries, ACK timeout and pulses.
    always_comb begin
        active_d     = active_q;
        arg_d        = arg_q;
        has_arg_d    = has_arg_q;
        cur_d        = cur_q;
        cur_is_arg_d = cur_is_arg_q;
        pending_d    = pending_q;
        await_d      = await_q;
        retry_d      = retry_q;
        tmo_d        = tmo_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        accept       = cmd_valid_i && ready_q;

        if (wr_done) begin
            pending_d = 1'b0;
            await_d   = 1'b1;
            tmo_d     = TW'(TMO_LOAD);
        end else if (await_q && tmo_q != '0) begin
            tmo_d = tmo_q - TW'(1);
        end

        if (ack_evt) begin
            await_d = 1'b0;
            retry_d = '0;
            if (!cur_is_arg_q && has_arg_q) begin
                cur_d        = arg_q;
                cur_is_arg_d = 1'b1;
                pending_d    = 1'b1;
            end else begin
                done_d   = 1'b1;
                active_d = 1'b0;
            end
        end else if (resend_evt) begin
            await_d = 1'b0;
            if (retry_q < RW'(pRetries)) begin
                retry_d   = retry_q + RW'(1);
                pending_d = 1'b1;
            end else begin
                err_d    = 1'b1;
                active_d = 1'b0;
            end
        end

        if (accept) begin
            active_d     = 1'b1;
            arg_d        = cmd_arg_i;
            has_arg_d    = cmd_has_arg_i;
            cur_d        = cmd_byte_i;
            cur_is_arg_d = 1'b0;
            pending_d    = 1'b1;
            await_d      = 1'b0;
            retry_d      = '0;
        end

        // Registered from active_q so ready reappears the cycle after a pulse.
        ready_d = !active_q && !accept;
    end

    // Rx FIFO pointers; a push into a full FIFO only succeeds alongside a pop.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        fifo_we   = 1'b0;
        fifo_full = (cnt_q == CW'(pFifoDepth));
        fifo_pop  = (cnt_q != '0) && rx_ready_i;

        if (fifo_push) begin
            if (!fifo_full || fifo_pop) begin
                fifo_we = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (fifo_we) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (fifo_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (fifo_we && !fifo_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!fifo_we && fifo_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            gap_q        <= '0;
            cs_q         <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= 2'd0;
            dout_q       <= 8'h00;
            par_q        <= 1'b0;
            active_q     <= 1'b0;
            arg_q        <= 8'h00;
            has_arg_q    <= 1'b0;
            cur_q        <= 8'h00;
            cur_is_arg_q <= 1'b0;
            pending_q    <= 1'b0;
            await_q      <= 1'b0;
            retry_q      <= '0;
            tmo_q        <= '0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            perr_q       <= 1'b0;
            ovf_q        <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            cs_q         <= cs_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dout_q       <= dout_d;
            par_q        <= par_d;
            active_q     <= active_d;
            arg_q        <= arg_d;
            has_arg_q    <= has_arg_d;
            cur_q        <= cur_d;
            cur_is_arg_q <= cur_is_arg_d;
            pending_q    <= pending_d;
            await_q      <= await_d;
            retry_q      <= retry_d;
            tmo_q        <= tmo_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
            perr_q       <= perr_d;
            ovf_q        <= ovf_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
        end
    end

    // FIFO storage; contents need no reset since the count gates the output.
    always_ff @(posedge clk_i) begin
        if (fifo_we) begin
            mem_q[wptr_q] <= fifo_wdata;
        end
    end

    assign kbd_cs_o    = cs_q;
    assign kbd_we_o    = we_q;
    assign kbd_adr_o   = adr_q;
    assign kbd_dat_o   = dout_q;
    assign cmd_ready_o = ready_q;
    assign cmd_done_o  = done_q;
    assign cmd_err_o   = err_q;
    assign perr_o      = perr_q;
    assign rx_ovf_o    = ovf_q;
    assign rx_valid_o  = (cnt_q != '0);
    assign rx_data_o   = (cnt_q != '0) ? mem_q[rptr_q] : 8'h00;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed bench for ps2_cmd_sequencer with a behavioural keyboard core.
module tb_ps2_cmd_sequencer;

    localparam int CLK_FREQ = 100000;   // 1 ms = 100 cycles
    localparam int TMO_MS   = 1;
    localparam int RETRIES  = 3;
    localparam int DEPTH    = 16;
    localparam int GAP      = 8;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       kbd_cs_o, kbd_we_o;
    logic [1:0] kbd_adr_o;
    logic [7:0] kbd_dat_o, kbd_dat_i;
    logic       kbd_ack_i;
    logic       cmd_valid_i, cmd_ready_o, cmd_has_arg_i;
    logic [7:0] cmd_byte_i, cmd_arg_i;
    logic       cmd_done_o, cmd_err_o;
    logic       rx_valid_o, rx_ready_i, rx_ovf_o, perr_o;
    logic [7:0] rx_data_o;
    logic [25:0] outs;

    int checks = 0;
    int errors = 0;

    // Core model state: pending device bytes, scripted replies, write log.
    logic [7:0] rxq_b[$];
    logic       rxq_p[$];
    int         reply_q[$];
    int         wlog[$];
    int         n_done = 0, n_err = 0, n_perr = 0;
    int         mdl_r;
    logic       mdl_hp;

    ps2_cmd_sequencer #(
        .pClkFreq(CLK_FREQ), .pAckTimeoutMs(TMO_MS), .pRetries(RETRIES),
        .pFifoDepth(DEPTH), .pPollGap(GAP)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .kbd_cs_o(kbd_cs_o), .kbd_we_o(kbd_we_o), .kbd_adr_o(kbd_adr_o),
        .kbd_dat_o(kbd_dat_o), .kbd_dat_i(kbd_dat_i), .kbd_ack_i(kbd_ack_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_byte_i(cmd_byte_i), .cmd_has_arg_i(cmd_has_arg_i), .cmd_arg_i(cmd_arg_i),
        .cmd_done_o(cmd_done_o), .cmd_err_o(cmd_err_o),
        .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i),
        .rx_ovf_o(rx_ovf_o), .perr_o(perr_o)
    );

    assign outs = {kbd_cs_o, kbd_we_o, kbd_adr_o, kbd_dat_o, cmd_ready_o, cmd_done_o,
                   cmd_err_o, rx_valid_o, rx_data_o, rx_ovf_o, perr_o};

    initial forever #5 clk_i = ~clk_i;

    // Keyboard core: acknowledges each access one cycle after cs rises.
    initial begin
        kbd_ack_i = 1'b0;
        kbd_dat_i = 8'h00;
        forever begin
            @(negedge clk_i);
            if (kbd_ack_i) begin
                kbd_ack_i = 1'b0;
                kbd_dat_i = 8'h00;
            end else if (kbd_cs_o) begin
                kbd_ack_i = 1'b1;
                if (!kbd_we_o) begin
                    mdl_hp = (rxq_p.size() != 0) ? rxq_p[0] : 1'b0;
                    if (kbd_adr_o == 2'd1)
                        kbd_dat_i = {rxq_b.size() != 0, 1'b1, 5'b00000, mdl_hp};
                    else
                        kbd_dat_i = (rxq_b.size() != 0) ? rxq_b[0] : 8'h00;
                end else begin
                    wlog.push_back(int'(kbd_adr_o) * 256 + int'(kbd_dat_o));
                    if (kbd_adr_o == 2'd1 && kbd_dat_o == 8'h00 && rxq_b.size() != 0) begin
                        void'(rxq_b.pop_front());
                        void'(rxq_p.pop_front());
                    end
                    if (kbd_adr_o == 2'd0 && reply_q.size() != 0) begin
                        mdl_r = reply_q.pop_front();
                        rxq_b.push_back(mdl_r[7:0]); rxq_p.push_back(1'b0);
                        if (mdl_r >= 256) begin
                            rxq_b.push_back(mdl_r[15:8]); rxq_p.push_back(1'b0);
                        end
                    end
                end
            end
        end
    end

    // Pulse counters.
    initial forever begin
        @(negedge clk_i);
        if (cmd_done_o) n_done++;
        if (cmd_err_o)  n_err++;
        if (perr_o)     n_perr++;
    end

    task automatic issue_cmd(input logic [7:0] b, input logic has, input logic [7:0] a);
        for (int i = 0; i < 100 && !cmd_ready_o; i++) @(negedge clk_i);
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++; $display("FAIL cmd_ready_wait: got %b expected 1", cmd_ready_o);
        end
        cmd_valid_i = 1'b1; cmd_byte_i = b; cmd_has_arg_i = has; cmd_arg_i = a;
        @(negedge clk_i);
        cmd_valid_i = 1'b0; cmd_has_arg_i = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string nm);
        int k = 0;
        while (!(cmd_done_o || cmd_err_o) && k < budget) begin
            @(negedge clk_i); k++;
        end
        checks++;
        if (!(cmd_done_o || cmd_err_o)) begin
            errors++; $display("FAIL %s_end: got no done/err pulse expected one within %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_rxq_empty(input int budget, input string nm);
        int k = 0;
        while (rxq_b.size() != 0 && k < budget) begin
            @(negedge clk_i); k++;
        end
        checks++;
        if (rxq_b.size() != 0) begin
            errors++; $display("FAIL %s_drain: got %0d bytes left expected 0", nm, rxq_b.size());
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_byte_i = 8'h00; cmd_has_arg_i = 1'b0;
        cmd_arg_i = 8'h00; rx_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (outs !== 26'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (cmd_ready_o !== 1'b1 || rx_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got ready=%b rx_valid=%b expected 1/0", cmd_ready_o, rx_valid_o);
        end
    endtask

    task automatic test_rx_drain();
        int k = 0;
        int base = wlog.size();
        rxq_b.push_back(8'h1C); rxq_p.push_back(1'b0);
        while (!rx_valid_o && k < 200) begin @(negedge clk_i); k++; end
        checks++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h1C) begin
            errors++; $display("FAIL rx_drain_data: got v=%b d=%h expected 1/1c", rx_valid_o, rx_data_o);
        end
        repeat (10) @(negedge clk_i);
        checks++;
        if (wlog.size() - base !== 1 || wlog[wlog.size()-1] !== 32'h100) begin
            errors++; $display("FAIL rx_drain_clr: got %0d writes last=%h expected 1 write of 100",
                               wlog.size() - base, wlog[wlog.size()-1]);
        end
        rx_ready_i = 1'b1; @(negedge clk_i); rx_ready_i = 1'b0;
        checks++;
        if (rx_valid_o !== 1'b0) begin
            errors++; $display("FAIL rx_drain_pop: got rx_valid=%b expected 0", rx_valid_o);
        end
    endtask

    task automatic test_led_cmd();
        int base = wlog.size();
        int d0 = n_done, e0 = n_err;
        int exp_log[4] = '{32'h0ED, 32'h100, 32'h002, 32'h100};
        int got;
        reply_q.push_back(32'hFA); reply_q.push_back(32'hFA);
        issue_cmd(8'hED, 1'b1, 8'h02);
        wait_end(2000, "led");
        checks++;
        if (cmd_done_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
            errors++; $display("FAIL led_pulse: got done=%b ready=%b expected 1/0", cmd_done_o, cmd_ready_o);
        end
        @(negedge clk_i);
        checks++;
        if (cmd_done_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            errors++; $display("FAIL led_ready_after: got done=%b ready=%b expected 0/1", cmd_done_o, cmd_ready_o);
        end
        repeat (30) @(negedge clk_i);
        checks++;
        if (wlog.size() - base !== 4) begin
            errors++; $display("FAIL led_log_len: got %0d expected 4", wlog.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            got = (base + i < wlog.size()) ? wlog[base+i] : -1;
            checks++;
            if (got !== exp_log[i]) begin
                errors++; $display("FAIL led_log[%0d]: got %h expected %h", i, got, exp_log[i]);
            end
        end
        checks++;
        if (n_done - d0 !== 1 || n_err - e0 !== 0 || rx_valid_o !== 1'b0) begin
            errors++; $display("FAIL led_counts: got done=%0d err=%0d rx_valid=%b expected 1/0/0",
                               n_done - d0, n_err - e0, rx_valid_o);
        end
    endtask

    task automatic test_resend();
        int base = wlog.size();
        int d0 = n_done, e0 = n_err;
        int exp_log[6] = '{32'h0F4, 32'h100, 32'h0F4, 32'h100, 32'h0F4, 32'h100};
        int got;
        reply_q.push_back(32'hFE); reply_q.push_back(32'hFE); reply_q.push_back(32'hFA);
        issue_cmd(8'hF4, 1'b0, 8'h00);
        wait_end(2000, "resend");
        repeat (30) @(negedge clk_i);
        checks++;
        if (wlog.size() - base !== 6) begin
            errors++; $display("FAIL resend_log_len: got %0d expected 6", wlog.size() - base);
        end
        for (int i = 0; i < 6; i++) begin
            got = (base + i < wlog.size()) ? wlog[base+i] : -1;
            checks++;
            if (got !== exp_log[i]) begin
                errors++; $display("FAIL resend_log[%0d]: got %h expected %h", i, got, exp_log[i]);
            end
        end
        checks++;
        if (n_done - d0 !== 1 || n_err - e0 !== 0) begin
            errors++; $display("FAIL resend_counts: got done=%0d err=%0d expected 1/0", n_done - d0, n_err - e0);
        end
    endtask

    task automatic test_dev_byte_during_cmd();
        int base = wlog.size();
        int d0 = n_done;
        reply_q.push_back(32'hFAAA);   // 0xAA arrives ahead of the ACK
        issue_cmd(8'hF4, 1'b0, 8'h00);
        wait_end(2000, "devbyte");
        repeat (30) @(negedge clk_i);
        checks++;
        if (n_done - d0 !== 1 || wlog.size() - base !== 3) begin
            errors++; $display("FAIL devbyte_done: got done=%0d writes=%0d expected 1/3", n_done - d0, wlog.size() - base);
        end
        checks++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'hAA) begin
            errors++; $display("FAIL devbyte_fifo: got v=%b d=%h expected 1/aa", rx_valid_o, rx_data_o);
        end
        rx_ready_i = 1'b1; @(negedge clk_i); rx_ready_i = 1'b0;
        checks++;
        if (rx_valid_o !== 1'b0) begin
            errors++; $display("FAIL devbyte_pop: got rx_valid=%b expected 0", rx_valid_o);
        end
    endtask

    task automatic test_timeout();
        int base = wlog.size();
        int d0 = n_done, e0 = n_err;
        int got, want;
        issue_cmd(8'hFF, 1'b0, 8'h00);
        wait_end(3000, "timeout");
        checks++;
        if (cmd_err_o !== 1'b1 || cmd_done_o !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse: got err=%b done=%b expected 1/0", cmd_err_o, cmd_done_o);
        end
        repeat (30) @(negedge clk_i);
        checks++;
        if (wlog.size() - base !== 8) begin
            errors++; $display("FAIL timeout_log_len: got %0d expected 8", wlog.size() - base);
        end
        for (int i = 0; i < 8; i++) begin
            got  = (base + i < wlog.size()) ? wlog[base+i] : -1;
            want = (i % 2 == 0) ? 32'h0FF : 32'h1FF;
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL timeout_log[%0d]: got %h expected %h", i, got, want);
            end
        end
        checks++;
        if (n_err - e0 !== 1 || n_done - d0 !== 0) begin
            errors++; $display("FAIL timeout_counts: got err=%0d done=%0d expected 1/0", n_err - e0, n_done - d0);
        end
    endtask

    task automatic test_parity();
        int p0 = n_perr;
        rxq_b.push_back(8'h55); rxq_p.push_back(1'b1);
        wait_rxq_empty(300, "parity");
        repeat (5) @(negedge clk_i);
        checks++;
        if (n_perr - p0 !== 1 || rx_valid_o !== 1'b0) begin
            errors++; $display("FAIL parity_drop: got perr=%0d rx_valid=%b expected 1/0", n_perr - p0, rx_valid_o);
        end
    endtask

    task automatic test_overflow();
        int k = 0;
        logic [7:0] want;
        rx_ready_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            rxq_b.push_back(8'(8'h10 + i)); rxq_p.push_back(1'b0);
        end
        wait_rxq_empty(2000, "ovf_fill");
        repeat (5) @(negedge clk_i);
        checks++;
        if (rx_ovf_o !== 1'b1 || rx_data_o !== 8'h10) begin
            errors++; $display("FAIL ovf_flag: got ovf=%b head=%h expected 1/10", rx_ovf_o, rx_data_o);
        end
        // Pop in the very cycle the next byte is captured from reg 0.
        rxq_b.push_back(8'h30); rxq_p.push_back(1'b0);
        while (!(kbd_cs_o && !kbd_we_o && kbd_adr_o == 2'd0) && k < 200) begin
            @(negedge clk_i); k++;
        end
        rx_ready_i = 1'b1; @(negedge clk_i); rx_ready_i = 1'b0;
        wait_rxq_empty(200, "ovf_simul");
        repeat (5) @(negedge clk_i);
        rx_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            want = (i < 15) ? 8'(8'h11 + i) : 8'h30;
            checks++;
            if (rx_valid_o !== 1'b1 || rx_data_o !== want) begin
                errors++; $display("FAIL ovf_entry[%0d]: got v=%b d=%h expected 1/%h", i, rx_valid_o, rx_data_o, want);
            end
            @(negedge clk_i);
        end
        rx_ready_i = 1'b0;
        checks++;
        if (rx_valid_o !== 1'b0 || rx_ovf_o !== 1'b1) begin
            errors++; $display("FAIL ovf_empty: got v=%b ovf=%b expected 0/1", rx_valid_o, rx_ovf_o);
        end
    endtask

    task automatic test_reset_mid_write();
        int k = 0;
        int base, n0;
        int d0 = n_done, e0 = n_err;
        issue_cmd(8'hF4, 1'b0, 8'h00);
        while (!(kbd_cs_o && kbd_we_o && kbd_adr_o == 2'd0) && k < 200) begin
            @(negedge clk_i); k++;
        end
        checks++;
        if (!(kbd_cs_o && kbd_we_o && kbd_adr_o == 2'd0 && kbd_dat_o == 8'hF4)) begin
            errors++; $display("FAIL rstmid_wr: got cs=%b we=%b adr=%0d d=%h expected 1/1/0/f4",
                               kbd_cs_o, kbd_we_o, kbd_adr_o, kbd_dat_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (outs !== 26'd0) begin
            errors++; $display("FAIL rstmid_outputs: got %h expected 0", outs);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        base = wlog.size();
        repeat (2) @(negedge clk_i);
        checks++;
        if (cmd_ready_o !== 1'b1 || rx_ovf_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: got ready=%b ovf=%b expected 1/0", cmd_ready_o, rx_ovf_o);
        end
        repeat (60) @(negedge clk_i);
        n0 = 0;
        for (int i = base; i < wlog.size(); i++) if (wlog[i] < 256) n0++;
        checks++;
        if (n0 !== 0 || n_done - d0 !== 0 || n_err - e0 !== 0) begin
            errors++; $display("FAIL rstmid_dropped: got data_writes=%0d done=%0d err=%0d expected 0/0/0",
                               n0, n_done - d0, n_err - e0);
        end
    endtask

    initial begin
        test_reset();
        test_rx_drain();
        test_led_cmd();
        test_resend();
        test_dev_byte_during_cmd();
        test_timeout();
        test_parity();
        test_overflow();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
